// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, status bit positions and defaults for the UART TX block
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} tx_state_t;
  localparam int OVF = 11;
  localparam int BUSY = 10;
  localparam int EMPTY = 9;
  localparam int FULL = 8;
  localparam int DEFAULT_BAUD_DIVIDER = 434;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with registered pointers and a combinational head word
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [7:0]       count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == 8'(DEPTH);
  assign empty = count == 8'd0;
  assign do_pop = pop & ~empty;
  // a pop on the same edge frees a slot, so a push into a full FIFO still lands
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + 8'(do_push) - 8'(do_pop);
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: bus-mapped 8N1 UART transmitter fed by a TX FIFO, with a readable status word
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIVIDER = DEFAULT_BAUD_DIVIDER,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        serial_out,
  output logic        tx_idle
);
  localparam logic [19:0] TMAX = 20'(BAUD_DIVIDER - 1);
  tx_state_t state;
  logic rdy, held, overflow, accept, wr, rd, pop, full, empty, tick;
  logic [7:0] dout, count, shifter;
  logic [19:0] timer;
  logic [2:0] bitcnt;
  logic unused_bits;
  assign unused_bits = ^{mem_instr, mem_addr, mem_wdata[31:8]};
  // held blocks re-acceptance while the master keeps mem_valid asserted
  assign accept = mem_valid & enable & ~rdy & ~held;
  assign wr = accept & |mem_wstrb;
  assign rd = accept & ~|mem_wstrb;
  assign tick = timer == TMAX;
  assign pop = ~empty & (state == IDLE | (state == STOP & tick));
  assign mem_ready = rdy;
  assign tx_idle = empty & (state == IDLE);
  always_comb begin
    mem_rdata = '0;
    if (enable) begin
      mem_rdata[7:0] = count;
      mem_rdata[FULL] = full;
      mem_rdata[EMPTY] = empty;
      mem_rdata[BUSY] = state != IDLE;
      mem_rdata[OVF] = overflow;
    end
  end
  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .push(wr),
    .pop(pop),
    .din(mem_wdata[7:0]),
    .dout(dout),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rdy <= 1'b0;
      held <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rdy <= accept;
      held <= mem_valid & enable & (held | accept);
      overflow <= (wr & full & ~pop) | (overflow & ~rd);
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      serial_out <= 1'b1;
      timer <= '0;
      bitcnt <= '0;
      shifter <= '0;
    end else begin
      timer <= (state == IDLE || tick) ? '0 : timer + 20'd1;
      case (state)
        IDLE:
          if (!empty) begin
            state <= START;
            shifter <= dout;
            serial_out <= 1'b0;
          end
        START:
          if (tick) begin
            state <= DATA;
            serial_out <= shifter[0];
            shifter <= shifter >> 1;
            bitcnt <= '0;
          end
        DATA:
          if (tick) begin
            if (bitcnt == 3'd7) begin
              state <= STOP;
              serial_out <= 1'b1;
            end else begin
              serial_out <= shifter[0];
              shifter <= shifter >> 1;
              bitcnt <= bitcnt + 3'd1;
            end
          end
        STOP:
          if (tick) begin
            if (!empty) begin
              state <= START;
              shifter <= dout;
              serial_out <= 1'b0;
            end else state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench decoding serial frames from two differently sized instances
module tb_uart_tx_fifo;
  localparam int B0 = 8;
  localparam int B1 = 200;
  logic clk = 0, resetn = 1, mem_valid = 0, mem_instr = 0;
  logic [1:0] en = 0;
  logic [3:0] mem_wstrb = 0;
  logic [31:0] mem_wdata = 0, mem_addr = 0;
  logic rdy0, rdy1, so0, so1, idle0, idle1;
  logic [31:0] rdata0, rdata1;
  logic [1:0] so, idle;
  int checks = 0, errors = 0, cyc = 0, frames1 = 0;
  bit [1:0] mon_off = 0;
  logic [7:0] q0[$], q1[$];
  int st0[$];
  assign so = {so1, so0};
  assign idle = {idle1, idle0};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_tx_fifo #(.BAUD_DIVIDER(B0), .FIFO_DEPTH(16)) dut0 (
    .clk(clk), .resetn(resetn), .enable(en[0]), .mem_valid(mem_valid), .mem_ready(rdy0),
    .mem_instr(mem_instr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .mem_rdata(rdata0), .serial_out(so0), .tx_idle(idle0)
  );
  uart_tx_fifo #(.BAUD_DIVIDER(B1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .resetn(resetn), .enable(en[1]), .mem_valid(mem_valid), .mem_ready(rdy1),
    .mem_instr(mem_instr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .mem_rdata(rdata1), .serial_out(so1), .tx_idle(idle1)
  );
  task automatic monitor(input int s, input int b);
    logic [7:0] d, e;
    logic stop;
    int t;
    forever begin
      @(negedge clk);
      if (resetn && so[s] === 1'b0) begin
        t = cyc;
        repeat (b / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (b) @(negedge clk);
          d[i] = so[s];
        end
        repeat (b) @(negedge clk);
        stop = so[s];
        if (!mon_off[s]) begin
          checks++;
          if ((s == 0 ? q0.size() : q1.size()) == 0) begin
            errors++;
            $display("FAIL frame%0d unexpected byte got %h", s, d);
          end else begin
            e = (s == 0) ? q0.pop_front() : q1.pop_front();
            if (d !== e || stop !== 1'b1) begin
              errors++;
              $display("FAIL frame%0d got %h stop %b expected %h stop 1", s, d, stop, e);
            end
          end
          if (s == 0) st0.push_back(t);
          else frames1++;
        end
      end
    end
  endtask
  initial monitor(0, B0);
  initial monitor(1, B1);
  task automatic bus(input int s, input bit wr, input logic [7:0] d, output logic [31:0] rdat);
    int n;
    @(negedge clk);
    mem_valid = 1;
    en[s] = 1;
    mem_wstrb = wr ? 4'hF : 4'h0;
    mem_wdata = {24'h0, d};
    #1 rdat = (s == 0) ? rdata0 : rdata1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((s == 0 ? rdy0 : rdy1) !== 1'b1 && n < 4);
    checks++;
    if ((s == 0 ? rdy0 : rdy1) !== 1'b1) begin
      errors++;
      $display("FAIL bus_ready%0d got 0 expected 1 within 4 cycles", s);
    end
    mem_valid = 0;
    en[s] = 0;
    mem_wstrb = 0;
  endtask
  task automatic write_byte(input int s, input logic [7:0] d);
    logic [31:0] r;
    bus(s, 1'b1, d, r);
  endtask
  task automatic wait_idle(input int s, input int budget);
    int n = 0;
    while (idle[s] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (idle[s] !== 1'b1) begin
      errors++;
      $display("FAIL idle_timeout%0d got tx_idle %b expected 1 within %0d cycles", s, idle[s], budget);
    end
    repeat (4) @(negedge clk);
  endtask
  task automatic test_reset;
    logic [31:0] r;
    #2 resetn = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({so1, so0, idle1, idle0, rdy1, rdy0} !== 6'b111100) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 111100", {so1, so0, idle1, idle0, rdy1, rdy0});
    end
    resetn = 1;
    bus(0, 1'b0, 8'h0, r);
    checks++;
    if (r !== 32'h200) begin
      errors++;
      $display("FAIL reset_status0 got %h expected 00000200", r);
    end
    bus(1, 1'b0, 8'h0, r);
    checks++;
    if (r !== 32'h200) begin
      errors++;
      $display("FAIL reset_status1 got %h expected 00000200", r);
    end
    @(negedge clk);
    checks++;
    if (rdata0 !== 32'h0) begin
      errors++;
      $display("FAIL rdata_disabled got %h expected 00000000", rdata0);
    end
  endtask
  task automatic test_single_byte;
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    q0.push_back(8'hA5);
    write_byte(0, 8'hA5);
    checks++;
    if (so0 !== 1'b1) begin
      errors++;
      $display("FAIL start_latency got serial_out %b on accept edge expected 1", so0);
    end
    for (int k = 0; k < 10 * B0; k++) begin
      @(negedge clk);
      checks++;
      if (so0 !== frame[k / B0]) begin
        errors++;
        $display("FAIL single_bit cycle %0d got %b expected %b", k, so0, frame[k / B0]);
      end
    end
    checks++;
    if (idle0 !== 1'b0) begin
      errors++;
      $display("FAIL idle_in_stop got %b expected 0", idle0);
    end
    @(negedge clk);
    checks++;
    if (idle0 !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_frame got %b expected 1", idle0);
    end
    wait_idle(0, 100);
  endtask
  task automatic test_back_to_back;
    logic [31:0] r;
    int n;
    n = st0.size();
    for (int i = 1; i <= 3; i++) begin
      q0.push_back(8'(i));
      write_byte(0, 8'(i));
    end
    bus(0, 1'b0, 8'h0, r);
    checks++;
    if (r[10] !== 1'b1 || (r[7:0] !== 8'd1 && r[7:0] !== 8'd2)) begin
      errors++;
      $display("FAIL b2b_status got %h expected busy=1 count=1 or 2", r);
    end
    wait_idle(0, 400);
    checks++;
    if (st0.size() !== n + 3) begin
      errors++;
      $display("FAIL b2b_frames got %0d expected 3", st0.size() - n);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (st0[n + i] - st0[n + i - 1] !== 10 * B0) begin
          errors++;
          $display("FAIL b2b_gap got %0d expected %0d", st0[n + i] - st0[n + i - 1], 10 * B0);
        end
      end
    end
  endtask
  task automatic test_held_valid;
    logic [31:0] r;
    int pulses = 0;
    q0.push_back(8'h11);
    write_byte(0, 8'h11);
    q0.push_back(8'h5A);
    @(negedge clk);
    mem_valid = 1;
    en[0] = 1;
    mem_wstrb = 4'hF;
    mem_wdata = 32'h5A;
    repeat (5) begin
      @(negedge clk);
      if (rdy0 === 1'b1) pulses++;
    end
    mem_valid = 0;
    en[0] = 0;
    mem_wstrb = 0;
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL held_ready_pulses got %0d expected 1", pulses);
    end
    bus(0, 1'b0, 8'h0, r);
    checks++;
    if (r !== 32'h401) begin
      errors++;
      $display("FAIL held_status got %h expected 00000401", r);
    end
    wait_idle(0, 300);
  endtask
  task automatic test_overflow;
    logic [31:0] r;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) q1.push_back(8'h30 + 8'(i));
      write_byte(1, 8'h30 + 8'(i));
    end
    bus(1, 1'b0, 8'h0, r);
    checks++;
    if (r !== 32'hD04) begin
      errors++;
      $display("FAIL ovf_status got %h expected 00000d04", r);
    end
    bus(1, 1'b0, 8'h0, r);
    checks++;
    if (r !== 32'h504) begin
      errors++;
      $display("FAIL ovf_cleared got %h expected 00000504", r);
    end
    wait_idle(1, 12 * B1 * 5);
    checks++;
    if (frames1 !== 5 || q1.size() !== 0) begin
      errors++;
      $display("FAIL ovf_frames got %0d left %0d expected 5 left 0", frames1, q1.size());
    end
  endtask
  task automatic test_reset_mid_frame;
    int lows = 0;
    q0.push_back(8'h0F);
    write_byte(0, 8'h0F);
    repeat (45) @(negedge clk);
    checks++;
    if (so0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_bit4 got %b expected 0", so0);
    end
    mon_off[0] = 1;
    #1 resetn = 0;
    #1;
    checks++;
    if (so0 !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_line got %b expected 1", so0);
    end
    en[0] = 1;
    #1;
    checks++;
    if (rdata0 !== 32'h200 || idle0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_fifo got status %h idle %b expected 00000200 idle 1", rdata0, idle0);
    end
    en[0] = 0;
    q0.delete();
    @(negedge clk);
    resetn = 1;
    repeat (300) begin
      @(negedge clk);
      if (so0 !== 1'b1 || idle0 !== 1'b1) lows++;
    end
    checks++;
    if (lows !== 0) begin
      errors++;
      $display("FAIL post_reset_quiet got %0d active cycles expected 0", lows);
    end
  endtask
  initial begin
    test_reset;
    test_single_byte;
    test_back_to_back;
    test_held_valid;
    test_overflow;
    test_reset_mid_frame;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
